mp_add_seq: RTL and testbench



---
 rtl/mp_add_pkg.sv | 19 +
 rtl/adder.sv | 40 ++++
 rtl/mp_add_seq.sv | 132 +++++++++++++
 tb/tb_mp_add_seq.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mp_add_pkg.sv
// mp_add_pkg: shared types and constants for the multi-precision add sequencer.
//   state_t  : sequencer FSM states (IDLE, RUN, DONE)
//   ADDER_W  : width of the 16-bit prefix adder slice
//   cnt_w()  : word-counter width for a given word count
package mp_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int ADDER_W = 16;

  function automatic int cnt_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/adder.sv
// adder: 16-bit Kogge-Stone parallel-prefix adder, fully combinational.
// Ports:
//   cout  out 1   carry out of bit 15
//   sum   out 16  a + b + cin (mod 2^16)
//   a     in  16  operand A
//   b     in  16  operand B
//   cin   in  1   carry into bit 0
module adder (
  output logic        cout,
  output logic [15:0] sum,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin
);

  logic [16:0] carry;

  // Position 0 carries cin as a pure generate term; position i+1 is bit i.
  // After the prefix tree, carry[i] is the carry into bit i.
  always_comb begin
    logic [16:0] gg, pp, gn, pn;
    gg = {a & b, cin};
    pp = {a ^ b, 1'b0};
    for (int d = 1; d < 17; d = d * 2) begin
      gn = gg;
      pn = pp;
      for (int i = d; i < 17; i++) begin
        gn[i] = gg[i] | (pp[i] & gg[i-d]);
        pn[i] = pp[i] & pp[i-d];
      end
      gg = gn;
      pp = pn;
    end
    carry = gg;
  end

  assign sum  = (a ^ b) ^ carry[15:0];
  assign cout = carry[16];

endmodule

// File: rtl/mp_add_seq.sv
// mp_add_seq: multi-precision add sequencer. Streams NWORDS words of WORD_W
// bits, least significant first, through one 16-bit prefix adder, keeping the
// inter-word carry in a register. One operation takes NWORDS RUN cycles.
// Ports:
//   clk, reset           clock (rising edge), synchronous active-high reset
//   in_valid / in_ready  operand handshake; in_ready is high only in IDLE
//   a, b, cin            operands (W = WORD_W*NWORDS bits), captured on accept
//   sub                  subtract select, only with MP_ADD_SUB_EN defined
//   out_valid/out_ready  result handshake; out_valid held until out_ready
//   sum, cout            W-bit result and carry out of the top word
// Build option: MP_ADD_SUB_EN adds the `sub` port (a - b when sub=1,
// cout=1 meaning no borrow). Undefined: add only.
module mp_add_seq
  import mp_add_pkg::*;
#(
  parameter int WORD_W = 16,
  parameter int NWORDS = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WORD_W*NWORDS-1:0] a,
  input  logic [WORD_W*NWORDS-1:0] b,
  input  logic                     cin,
`ifdef MP_ADD_SUB_EN
  input  logic                     sub,
`endif
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WORD_W*NWORDS-1:0] sum,
  output logic                     cout
);

  localparam int W     = WORD_W * NWORDS;
  localparam int CNT_W = cnt_w(NWORDS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NWORDS - 1);

  if (WORD_W != ADDER_W) begin : g_bad_word_w
    $error("mp_add_seq: WORD_W must equal the adder width (16)");
  end
  if (NWORDS < 2) begin : g_bad_nwords
    $error("mp_add_seq: NWORDS must be at least 2");
  end

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [W-1:0]     a_sh;
  logic [W-1:0]     b_sh;
  logic [W-1:0]     res;
  logic             carry;
  logic             cout_q;
  logic             out_valid_q;

  logic [WORD_W-1:0] b_word;
  logic [WORD_W-1:0] add_sum;
  logic              add_cout;
  logic              cin_first;

`ifdef MP_ADD_SUB_EN
  logic sub_q;
  // Subtraction as a + ~b + 1: invert every b word, force carry-in to 1.
  assign b_word    = sub_q ? ~b_sh[WORD_W-1:0] : b_sh[WORD_W-1:0];
  assign cin_first = sub ? 1'b1 : cin;
`else
  assign b_word    = b_sh[WORD_W-1:0];
  assign cin_first = cin;
`endif

  adder u_adder (
    .cout (add_cout),
    .sum  (add_sum),
    .a    (a_sh[WORD_W-1:0]),
    .b    (b_word),
    .cin  (carry)
  );

  assign in_ready  = (state == IDLE);
  assign out_valid = out_valid_q;
  assign sum       = res;
  assign cout      = cout_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      carry       <= 1'b0;
      res         <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin_first;
`ifdef MP_ADD_SUB_EN
            sub_q <= sub;
`endif
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          // Each sum word enters at the top, so after NWORDS shifts word 0
          // has reached the bottom of the result register.
          res   <= {add_sum, res[W-1:WORD_W]};
          carry <= add_cout;
          a_sh  <= a_sh >> WORD_W;
          b_sh  <= b_sh >> WORD_W;
          if (cnt == CNT_LAST) begin
            cnt         <= '0;
            cout_q      <= add_cout;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mp_add_seq.sv
// tb_mp_add_seq: directed testbench for mp_add_seq with NWORDS=4 (W=64).
module tb_mp_add_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a;
  logic [63:0] b;
  logic        cin;
`ifdef MP_ADD_SUB_EN
  logic        sub;
`endif
  logic        out_valid;
  logic        out_ready;
  logic [63:0] sum;
  logic        cout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mp_add_seq #(.WORD_W(16), .NWORDS(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef MP_ADD_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present an operand at a negedge and let the next rising edge accept it.
  task automatic accept(input logic [63:0] av, input logic [63:0] bv, input logic cv,
                        input logic sv);
    @(negedge clk);
    a = av; b = bv; cin = cv; in_valid = 1'b1;
`ifdef MP_ADD_SUB_EN
    sub = sv;
`else
    if (sv) $display("note: sub requested in add-only build");
`endif
    check("accept_in_ready", {63'b0, in_ready}, 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Count edges until out_valid appears; expect exactly NWORDS after accept.
  task automatic wait_valid(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 20);
    check({tag, "_latency"}, 64'(n - 1), 64'd4);
  endtask

  task automatic finish_op(input string tag, input logic [63:0] es, input logic ec);
    check({tag, "_sum"}, sum, es);
    check({tag, "_cout"}, {63'b0, cout}, {63'b0, ec});
    check({tag, "_busy"}, {63'b0, in_ready}, 64'd0);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check({tag, "_drop"}, {63'b0, out_valid}, 64'd0);
    check({tag, "_idle"}, {63'b0, in_ready}, 64'd1);
  endtask

  initial begin
    logic [63:0] held;
    logic [63:0] va [3];
    logic [63:0] vb [3];
    logic [63:0] es [3];
    logic        ec [3];
    int acc_cyc [3];
    int acc;
    int res;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;
`ifdef MP_ADD_SUB_EN
    sub = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_out_valid", {63'b0, out_valid}, 64'd0);
    check("rst_sum", sum, 64'd0);
    check("rst_cout", {63'b0, cout}, 64'd0);
    check("rst_in_ready", {63'b0, in_ready}, 64'd1);

    // Word-0 carry into word 1
    accept(64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 1'b0);
    wait_valid("t1");
    finish_op("t1", 64'h0000_0000_0001_0000, 1'b0);

    // cin ripples through all four words
    accept(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0);
    wait_valid("t2");
    finish_op("t2", 64'd0, 1'b1);

    // Mixed carries between words
    accept(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0);
    wait_valid("t2b");
    finish_op("t2b", 64'h2222_2222_2222_2211, 1'b0);

    accept(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    wait_valid("t2c");
    finish_op("t2c", 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);

    // Back-pressure in DONE with a competing request
    accept(64'h0000_0001_0000_0002, 64'h0000_0003_0000_0004, 1'b0, 1'b0);
    wait_valid("t3");
    held = 64'h0000_0004_0000_0006;
    check("t3_sum", sum, held);
    in_valid = 1'b1; a = 64'hDEAD_BEEF_DEAD_BEEF; b = 64'h1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t3_hold_valid", {63'b0, out_valid}, 64'd1);
      check("t3_hold_sum", sum, held);
      check("t3_hold_ready", {63'b0, in_ready}, 64'd0);
    end
    in_valid = 1'b0;
    finish_op("t3", held, 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("t3_no_accept", {63'b0, out_valid}, 64'd0);
    end
    check("t3_sum_kept", sum, held);

    // Reset in the second RUN cycle aborts the operation
    accept(64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("t4_out_valid", {63'b0, out_valid}, 64'd0);
    check("t4_sum", sum, 64'd0);
    check("t4_in_ready", {63'b0, in_ready}, 64'd1);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("t4_no_stale", {63'b0, out_valid}, 64'd0);
    end

    // Continuous requests with a ready sink
    va[0] = 64'd1;                  vb[0] = 64'd2;
    es[0] = 64'd3;                  ec[0] = 1'b0;
    va[1] = 64'h0000_0000_0000_FFFF; vb[1] = 64'h0000_0000_0000_FFFF;
    es[1] = 64'h0000_0000_0001_FFFE; ec[1] = 1'b0;
    va[2] = 64'hFFFF_FFFF_0000_0000; vb[2] = 64'h0000_0001_0000_0000;
    es[2] = 64'd0;                  ec[2] = 1'b1;
    acc = 0; res = 0;
    out_ready = 1'b1; cin = 1'b0;
    for (int cyc = 0; cyc < 40 && res < 3; cyc++) begin
      @(negedge clk);
      if (out_valid) begin
        check("t5_sum", sum, es[res]);
        check("t5_cout", {63'b0, cout}, {63'b0, ec[res]});
        res++;
      end
      if (in_ready && acc < 3) begin
        a = va[acc]; b = vb[acc]; in_valid = 1'b1;
        acc_cyc[acc] = cyc;
        acc++;
      end else if (acc >= 3) begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check("t5_results", 64'(res), 64'd3);
    check("t5_spacing1", 64'(acc_cyc[1] - acc_cyc[0]), 64'd6);
    check("t5_spacing2", 64'(acc_cyc[2] - acc_cyc[1]), 64'd6);

`ifdef MP_ADD_SUB_EN
    accept(64'd5, 64'd7, 1'b0, 1'b1);
    wait_valid("t6a");
    finish_op("t6a", 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
    accept(64'd7, 64'd5, 1'b0, 1'b1);
    wait_valid("t6b");
    finish_op("t6b", 64'd2, 1'b1);
    accept(64'd7, 64'd5, 1'b0, 1'b0);
    wait_valid("t6c");
    finish_op("t6c", 64'd12, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
